// File: rtl/rr_mux_arb_if.sv
// Bundle of the channel-side and consumer-side handshake signals of rr_mux_arb.
// The master modport is the environment (producers + consumer); the slave
// modport is the arbiter itself.
interface rr_mux_arb_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic                 mode;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with round-robin / fixed-priority arbitration.
// A single output register gives one cycle of latency and full throughput.
//
// Handshake: a word moves across any valid/ready pair exactly at a rising edge
// where both valid and ready are high. Producers may drop valid without a
// transfer and need not hold payload stable. in_ready is one-hot or zero and
// depends combinationally on out_ready, in_valid and mode; out_valid/out_data
// stay constant while out_valid=1 and out_ready=0.
module rr_mux_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_arb_if.slave  bus
);
    localparam int SELW = $clog2(N);

    logic [SELW-1:0]  last;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic             load;
    logic [WIDTH-1:0] grant_data;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;
    logic             out_valid_q;

    // The output register can take a new word when empty or being drained.
    assign load = ~out_valid_q | bus.out_ready;

    // Grant selection: rotating search after 'last', or lowest index first.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (bus.mode) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[k]) begin
                    grant       = SELW'(k);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                idx = (int'(last) + i) % N;
                if (!grant_valid && bus.in_valid[idx]) begin
                    grant       = SELW'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Payload of the granted channel.
    always_comb begin
        grant_data = bus.in_data[grant*WIDTH +: WIDTH];
    end

    // One-hot ready toward the granted channel; forced low while in reset.
    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < N; k++) begin
            bus.in_ready[k] = ~rst & load & grant_valid & (grant == SELW'(k));
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            last        <= SELW'(N - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_data_q  <= grant_data;
                out_sel_q   <= grant;
                out_valid_q <= 1'b1;
                last        <= grant;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: directed scenarios plus randomized
// traffic, all checked against a behavioural arbitration model.
module tb_rr_mux_arb;
    localparam int W = 8;
    localparam int N = 4;

    logic clk;
    logic rst;
    rr_mux_arb_if #(.WIDTH(W), .N(N)) bus ();

    rr_mux_arb #(.WIDTH(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    bit             m_valid;
    logic [W-1:0]   m_data;
    int             m_sel;
    int             m_last;
    logic [W-1:0]   exp_q[$];
    logic [N*W-1:0] data_vec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winning channel by the arbitration rules, or -1 when nothing is valid.
    function automatic int exp_grant(bit m, logic [N-1:0] v, int last);
        if (m) begin
            for (int k = 0; k < N; k++) if (v[k]) return k;
        end else begin
            for (int off = 1; off <= N; off++) if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_last  = N - 1;
        exp_q.delete();
    endtask

    task automatic set_abc_data();
        for (int k = 0; k < N; k++) data_vec[k*W +: W] = W'(8'hA0 + k);
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input bit m, input logic [N-1:0] v, input bit ordy);
        int g;
        bit ld;
        logic [N-1:0] exp_rdy;
        bus.mode      = m;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.in_data   = data_vec;
        #1;
        g       = exp_grant(m, v, m_last);
        ld      = !m_valid || ordy;
        exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (m_valid && ordy) begin
            check("drain_q_size", exp_q.size(), 1);
            if (exp_q.size() > 0) check("drain_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = data_vec[g*W +: W];
                m_sel   = g;
                m_last  = g;
                exp_q.push_back(m_data);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_sel", 32'(bus.out_sel), m_sel);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rmode;
        rst = 1'b1;
        bus.mode = 1'b0; bus.in_valid = '0; bus.out_ready = 1'b0; bus.in_data = '0;
        data_vec = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_sel", 32'(bus.out_sel), 0);
        rst = 1'b0;

        // Round-robin with all channels valid: 0,1,2,3,0,1 back to back.
        set_abc_data();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            check("rr_seq_sel", 32'(bus.out_sel), i % N);
            check("rr_seq_data", 32'(bus.out_data), 32'(8'hA0 + (i % N)));
        end

        // Fixed priority: ch1 always wins over ch3, then ch3 alone.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b1010, 1'b1);
            check("fp_ch1", 32'(bus.out_data), 32'h A1);
        end
        cycle(1'b1, 4'b1000, 1'b1);
        check("fp_ch3", 32'(bus.out_data), 32'h A3);

        // Backpressure: A2 held for 3 cycles, then ch3 taken on release.
        cycle(1'b0, 4'b0100, 1'b1);
        check("bp_load_a2", 32'(bus.out_data), 32'h A2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            check("bp_hold_data", 32'(bus.out_data), 32'h A2);
            check("bp_hold_ready", 32'(bus.in_ready), 0);
        end
        cycle(1'b0, 4'b1111, 1'b1);
        check("bp_release_a3", 32'(bus.out_data), 32'h A3);

        // Drain to empty: one word on ch2 then nothing.
        cycle(1'b0, 4'b0100, 1'b1);
        check("drain_valid1", 32'(bus.out_valid), 1);
        cycle(1'b0, 4'b0000, 1'b1);
        check("drain_valid0", 32'(bus.out_valid), 0);
        check("drain_keep", 32'(bus.out_data), 32'h A2);

        // Pointer wrap: last=1, only ch0 valid, then ch0+ch1.
        cycle(1'b0, 4'b0010, 1'b1);
        check("wrap_g1", 32'(bus.out_sel), 1);
        cycle(1'b0, 4'b0001, 1'b1);
        check("wrap_g0", 32'(bus.out_sel), 0);
        cycle(1'b0, 4'b0011, 1'b1);
        check("wrap_then_g1", 32'(bus.out_sel), 1);

        // Asynchronous reset between edges with a word held.
        cycle(1'b0, 4'b1111, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_out_data", 32'(bus.out_data), 0);
        check("arst_out_sel", 32'(bus.out_sel), 0);
        check("arst_in_ready", 32'(bus.in_ready), 0);
        model_reset();
        @(posedge clk); #1;
        check("arst_hold_ready", 32'(bus.in_ready), 0);
        check("arst_hold_valid", 32'(bus.out_valid), 0);
        #1 rst = 1'b0;
        cycle(1'b0, 4'b1111, 1'b1);
        check("arst_first_ch0", 32'(bus.out_sel), 0);

        // Randomized traffic.
        rmode = 1'b0;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < N; k++) data_vec[k*W +: W] = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) rmode = ~rmode;
            cycle(rmode, N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
